// File: rtl/data_ram_responder.sv
// Word-addressed data RAM: combinational core read port, clocked core write, ready/valid host port.
// Define DATA_RAM_CLEAR_EN to zero every word after reset (BUSY high while clearing).
module data_ram_responder #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] ADDR_RAM,
    input  logic [SIZE-1:0]       Q_W,
    input  logic                  ENABLE_W,
    output logic [SIZE-1:0]       Q_RAM,
    input  logic                  HOST_VALID,
    output logic                  HOST_READY,
    input  logic                  HOST_WE,
    input  logic [ADDR_WIDTH-1:0] HOST_ADDR,
    input  logic [SIZE-1:0]       HOST_WDATA,
    output logic                  HOST_RVALID,
    output logic [SIZE-1:0]       HOST_RDATA,
    output logic                  BUSY
);

    // state | meaning
    // IDLE  | serves core and host ports
    // RESP  | cycle after an accepted host read; HOST_RVALID high
    // CLEAR | zeroing mem[cnt], one word per cycle (clear build only)

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1
`ifdef DATA_RAM_CLEAR_EN
        ,
        CLEAR = 2'd2
`endif
    } state_t;

    logic [SIZE-1:0]       mem [DEPTH];
    state_t                state;
    logic                  busy;
    logic                  accept;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [SIZE-1:0]       wdata;

`ifdef DATA_RAM_CLEAR_EN
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    logic [ADDR_WIDTH:0] cnt;
    assign busy = (state == CLEAR);
`else
    assign busy = 1'b0;
`endif

    // Core has priority, so host and core never write in the same cycle.
    assign HOST_READY = (state == IDLE) && !ENABLE_W && !RESET;
    assign accept     = HOST_VALID && HOST_READY;
    assign BUSY       = busy;
    assign Q_RAM      = busy ? '0 : mem[ADDR_RAM];

    always_comb begin
        we    = 1'b0;
        waddr = ADDR_RAM;
        wdata = Q_W;
        if (!RESET) begin
`ifdef DATA_RAM_CLEAR_EN
            if (busy) begin
                we    = 1'b1;
                waddr = cnt[ADDR_WIDTH-1:0];
                wdata = '0;
            end else if (ENABLE_W) begin
`else
            if (ENABLE_W) begin
`endif
                we = 1'b1;
            end else if (accept && HOST_WE) begin
                we    = 1'b1;
                waddr = HOST_ADDR;
                wdata = HOST_WDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            HOST_RVALID <= 1'b0;
            HOST_RDATA  <= '0;
`ifdef DATA_RAM_CLEAR_EN
            state       <= CLEAR;
            cnt         <= '0;
`else
            state       <= IDLE;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !HOST_WE) begin
                        HOST_RDATA  <= mem[HOST_ADDR];
                        HOST_RVALID <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    HOST_RVALID <= 1'b0;
                    state       <= IDLE;
                end
`ifdef DATA_RAM_CLEAR_EN
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= IDLE;
                end
`endif
                default: begin
                    HOST_RVALID <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
